// File: rtl/bus_fabric_pkg.sv
// Shared types and default configuration for the bus fabric.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_N_SLAVES = 4;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_TIMEOUT  = 16;

  // Slot 0 lives in the LSBs of each table.
  localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_BASE_ADDRS =
    {32'h8000_0020, 32'h8000_0010, 32'h8000_0000, 32'h0000_0000};
  localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_ADDR_MASKS =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h8000_0000};

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_fabric_decoder.sv
// Combinational address decoder: lowest matching slot wins.
module bus_addr_decoder
  import bus_fabric_pkg::*;
#(
  parameter int unsigned                      N_SLAVES   = DEF_N_SLAVES,
  parameter int unsigned                      ADDR_W     = DEF_ADDR_W,
  parameter logic [N_SLAVES*ADDR_W-1:0]       BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [N_SLAVES*ADDR_W-1:0]       ADDR_MASKS = DEF_ADDR_MASKS,
  parameter int unsigned                      SEL_W      = clog2_min1(N_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel,
  output logic              hit
);

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) == BASE_ADDRS[i*ADDR_W +: ADDR_W]) begin
        sel = SEL_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric: decodes, forwards to one slave, waits for ack or timeout.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int unsigned                N_SLAVES   = DEF_N_SLAVES,
  parameter int unsigned                ADDR_W     = DEF_ADDR_W,
  parameter int unsigned                DATA_W     = DEF_DATA_W,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASKS = DEF_ADDR_MASKS,
  parameter int unsigned                TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       proc_rd_en_i,
  input  logic                       proc_wr_en_i,
  input  logic [ADDR_W-1:0]          proc_addr_i,
  input  logic [DATA_W-1:0]          proc_wdata_i,
  output logic [DATA_W-1:0]          proc_rdata_o,
  output logic                       proc_ack_o,
  output logic                       proc_err_o,
  output logic                       proc_busy_o,
  output logic [N_SLAVES-1:0]        slv_rd_en_o,
  output logic [N_SLAVES-1:0]        slv_wr_en_o,
  output logic [ADDR_W-1:0]          slv_addr_o,
  output logic [DATA_W-1:0]          slv_wdata_o,
  input  logic [N_SLAVES*DATA_W-1:0] slv_rdata_i,
  input  logic [N_SLAVES-1:0]        slv_ack_i,
  output logic [7:0]                 err_count_o
);

  localparam int unsigned SEL_W = clog2_min1(N_SLAVES);
  localparam int unsigned CNT_W = clog2_min1(TIMEOUT);

  state_t              state;
  logic [SEL_W-1:0]    dec_sel;
  logic                dec_hit;
  logic [SEL_W-1:0]    sel_q;
  logic                is_rd;
  logic [CNT_W-1:0]    wait_cnt;
  logic [N_SLAVES-1:0] dec_onehot;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic [7:0]          err_count_inc;
  logic                req_bad;

  bus_addr_decoder #(
    .N_SLAVES  (N_SLAVES),
    .ADDR_W    (ADDR_W),
    .BASE_ADDRS(BASE_ADDRS),
    .ADDR_MASKS(ADDR_MASKS),
    .SEL_W     (SEL_W)
  ) u_dec (
    .addr(proc_addr_i),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  assign dec_onehot    = N_SLAVES'(1) << dec_sel;
  assign sel_ack       = slv_ack_i[sel_q];
  assign sel_rdata     = slv_rdata_i[sel_q*DATA_W +: DATA_W];
  assign err_count_inc = (err_count_o == 8'hFF) ? 8'hFF : err_count_o + 8'd1;
  assign req_bad       = (proc_rd_en_i && proc_wr_en_i) || !dec_hit;

  // Transaction FSM with all processor and slave outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      is_rd        <= 1'b0;
      wait_cnt     <= '0;
      proc_rdata_o <= '0;
      proc_ack_o   <= 1'b0;
      proc_err_o   <= 1'b0;
      proc_busy_o  <= 1'b0;
      slv_rd_en_o  <= '0;
      slv_wr_en_o  <= '0;
      slv_addr_o   <= '0;
      slv_wdata_o  <= '0;
      err_count_o  <= '0;
    end else begin
      proc_ack_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (proc_rd_en_i || proc_wr_en_i) begin
            slv_addr_o  <= proc_addr_i;
            slv_wdata_o <= proc_wdata_i;
            is_rd       <= proc_rd_en_i;
            sel_q       <= dec_sel;
            wait_cnt    <= '0;
            proc_busy_o <= 1'b1;
            if (req_bad) begin
              state        <= ST_RESP;
              proc_ack_o   <= 1'b1;
              proc_err_o   <= 1'b1;
              proc_rdata_o <= '0;
              err_count_o  <= err_count_inc;
            end else begin
              state       <= ST_BUSY;
              slv_rd_en_o <= proc_rd_en_i ? dec_onehot : '0;
              slv_wr_en_o <= proc_wr_en_i ? dec_onehot : '0;
            end
          end
        end
        ST_BUSY: begin
          // Ack wins over a timeout landing on the same cycle.
          if (sel_ack) begin
            state        <= ST_RESP;
            proc_ack_o   <= 1'b1;
            proc_err_o   <= 1'b0;
            proc_rdata_o <= is_rd ? sel_rdata : '0;
            slv_rd_en_o  <= '0;
            slv_wr_en_o  <= '0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= ST_RESP;
            proc_ack_o   <= 1'b1;
            proc_err_o   <= 1'b1;
            proc_rdata_o <= '0;
            slv_rd_en_o  <= '0;
            slv_wr_en_o  <= '0;
            err_count_o  <= err_count_inc;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          proc_busy_o <= 1'b0;
          proc_err_o  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_SLAVES, 4, number of slave ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BASE_ADDRS, {0x8000_0020, 0x8000_0010, 0x8000_0000, 0x0000_0000}, flattened N_SLAVES×ADDR_W base table, slot 0 in the LSBs.
- ADDR_MASKS, {0xFFFF_FFF0, 0xFFFF_FFF0, 0xFFFF_FFF0, 0x8000_0000}, flattened match masks.
- TIMEOUT, 16, maximum wait cycles for a slave ack.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- proc_rd_en_i, in, 1, read request pulse.
- proc_wr_en_i, in, 1, write request pulse.
- proc_addr_i, in, ADDR_W, request address.
- proc_wdata_i, in, DATA_W, write data.
- proc_rdata_o, out, DATA_W, read data, valid with proc_ack_o.
- proc_ack_o, out, 1, one-cycle completion strobe.
- proc_err_o, out, 1, error flag, valid with proc_ack_o.
- proc_busy_o, out, 1, fabric not idle.
- slv_rd_en_o, out, N_SLAVES, per-slave read enable.
- slv_wr_en_o, out, N_SLAVES, per-slave write enable.
- slv_addr_o, out, ADDR_W, broadcast registered address.
- slv_wdata_o, out, DATA_W, broadcast registered write data.
- slv_rdata_i, in, N_SLAVES×DATA_W, flattened slave read data.
- slv_ack_i, in, N_SLAVES, per-slave completion.
- err_count_o, out, 8, saturating count of error responses.
REQ-003 One clock; reset is asynchronous and active-low, named clk and rst_n.

Function
REQ-004 Decode SHALL select slot i when (proc_addr_i & MASK[i]) == BASE[i]; the lowest matching index wins; no match means unmapped.
REQ-005 FSM states SHALL be IDLE, BUSY, RESP.
REQ-006 IDLE: a request (exactly one of rd/wr high) SHALL latch addr, wdata, direction and slot, and go to BUSY if the address is mapped, otherwise to RESP with err=1.
REQ-007 rd and wr both high in IDLE SHALL go to RESP with err=1 and produce no slave enable.
REQ-008 BUSY: slv_rd_en_o[sel] or slv_wr_en_o[sel] SHALL be held high, all other bits low, with slv_addr_o and slv_wdata_o stable, until ack or timeout.
REQ-009 In BUSY, slv_ack_i[sel] high SHALL capture slv_rdata_i[sel] (writes capture 0) and go to RESP with err=0; acks from non-selected slots are ignored.
REQ-010 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; reaching TIMEOUT-1 without ack SHALL go to RESP with err=1 and rdata=0.
REQ-011 An ack on the same cycle as the timeout SHALL take precedence (err=0).
REQ-012 RESP SHALL assert proc_ack_o for exactly one cycle with proc_rdata_o and proc_err_o valid, then return to IDLE; proc_rdata_o holds its value until the next RESP.
REQ-013 Latency SHALL be: request at cycle T, slave enable at T+1, zero-wait ack at T+1, proc_ack_o at T+2; an unmapped or illegal request gives proc_ack_o at T+1.
REQ-014 Requests arriving while not in IDLE SHALL be ignored, with no queueing.
REQ-015 proc_busy_o SHALL be high in BUSY and RESP.
REQ-016 err_count_o SHALL increment on every RESP with err=1 and saturate at 255.

Reset
REQ-017 Asynchronous reset SHALL force state=IDLE, all slave enables to 0, proc_ack_o/proc_err_o/proc_busy_o to 0, proc_rdata_o/slv_addr_o/slv_wdata_o to 0, wait counter to 0, and err_count_o to 0.
REQ-018 Reset mid-transaction SHALL abort it with no ack; after release the fabric SHALL accept a request on the first clock edge.

Structure
REQ-019 Package bus_fabric_pkg SHALL hold the FSM state encoding, the default base/mask tables and the default TIMEOUT.
REQ-020 A combinational sub-module bus_addr_decoder SHALL implement REQ-004 and output sel index plus a hit flag.

Verification
REQ-021 Read 0x0000_0004, slot 0 acks in the same cycle with 0x1234_5678 -> proc_ack_o at T+2, rdata=0x1234_5678, err=0.
REQ-022 Write 0x8000_0000 data 0xA5, slot 1 acks after 3 wait cycles -> slv_wr_en_o=4'b0010 held 4 cycles, then ack with err=0.
REQ-023 Read unmapped 0x8000_0100 -> no slave enable, ack at T+1, err=1, err_count_o=1.
REQ-024 Read slot 2, which never acks -> enable held 16 cycles, ack with err=1, rdata=0.
REQ-025 rd and wr both high -> err=1; a second request while busy is ignored; rst_n low during BUSY clears all outputs.
